i2c_reg_sequencer: RTL and testbench

- Upstream command sequencer for i2c_master.
- Converts one register-access request into the i2c_master command and data stream transactions: device address, 8-bit register address, and one data byte.
- Write request: S, addr+W, reg, data, P.
- Read request: S, addr+W, reg, Sr, addr+R, data with master NACK, P.
- Returns one response per request, carrying read data and a sticky missed-ACK error.

---
 rtl/i2c_reg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: one register read/write request -> i2c_master cmd/data.
// Optional per-transaction timeout: define I2C_REG_TIMEOUT_EN.
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [6:0] m_cmd_address,
  output logic       m_cmd_start,
  output logic       m_cmd_read,
  output logic       m_cmd_write,
  output logic       m_cmd_write_multiple,
  output logic       m_cmd_stop,
  output logic       m_cmd_valid,
  input  logic       m_cmd_ready,
  output logic [7:0] m_data_tdata,
  output logic       m_data_tvalid,
  output logic       m_data_tlast,
  input  logic       m_data_tready,
  input  logic [7:0] s_rd_tdata,
  input  logic       s_rd_tvalid,
  output logic       s_rd_tready,
  input  logic       s_rd_tlast,
  input  logic       i2c_busy,
  input  logic       i2c_missed_ack
);

  typedef enum logic [3:0] {
    IDLE, W_CMD, W_REG, W_VAL, W_WAIT,
    R_CMD_A, R_REG, R_CMD_R, R_DATA, RESP
  } state_t;

  state_t     state;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy_seen;
  logic       accept;
  logic       unused;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign unused = ^{s_rd_tlast, 32'(TIMEOUT_CYCLES)};

`ifdef I2C_REG_TIMEOUT_EN
  logic [31:0] cnt;
  logic        timeout;

  assign timeout = (state != IDLE) && (state != RESP) &&
                   (cnt == 32'(TIMEOUT_CYCLES - 1));

  // cycles spent in the active part of the current transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state != IDLE && state != RESP) begin
      cnt <= cnt + 32'd1;
    end
  end
`endif

  // request sequencing FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      dev_addr             <= '0;
      reg_addr             <= '0;
      wdata                <= '0;
      busy_seen            <= 1'b0;
      req_ready            <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
      rsp_err              <= 1'b0;
      m_cmd_address        <= '0;
      m_cmd_start          <= 1'b0;
      m_cmd_read           <= 1'b0;
      m_cmd_write          <= 1'b0;
      m_cmd_write_multiple <= 1'b0;
      m_cmd_stop           <= 1'b0;
      m_cmd_valid          <= 1'b0;
      m_data_tdata         <= '0;
      m_data_tvalid        <= 1'b0;
      m_data_tlast         <= 1'b0;
      s_rd_tready          <= 1'b0;
    end else begin
      if (state != IDLE) begin
        if (i2c_busy) busy_seen <= 1'b1;
        if (i2c_missed_ack) rsp_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready            <= 1'b0;
            dev_addr             <= req_dev_addr;
            reg_addr             <= req_reg_addr;
            wdata                <= req_wdata;
            rsp_err              <= 1'b0;
            busy_seen            <= 1'b0;
            m_cmd_address        <= req_dev_addr;
            m_cmd_start          <= 1'b1;
            m_cmd_read           <= 1'b0;
            m_cmd_write          <= req_rw;
            m_cmd_write_multiple <= !req_rw;
            m_cmd_stop           <= !req_rw;
            m_cmd_valid          <= 1'b1;
            state <= req_rw ? R_CMD_A : W_CMD;
          end
        end
        W_CMD: begin
          if (m_cmd_ready) begin
            m_cmd_valid   <= 1'b0;
            m_data_tdata  <= reg_addr;
            m_data_tlast  <= 1'b0;
            m_data_tvalid <= 1'b1;
            state         <= W_REG;
          end
        end
        W_REG: begin
          if (m_data_tready) begin
            m_data_tdata <= wdata;
            m_data_tlast <= 1'b1;
            state        <= W_VAL;
          end
        end
        W_VAL: begin
          if (m_data_tready) begin
            m_data_tvalid <= 1'b0;
            state         <= W_WAIT;
          end
        end
        W_WAIT: begin
          // busy_seen keeps us from finishing before the bus ever started
          if (!i2c_busy && busy_seen) begin
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        R_CMD_A: begin
          if (m_cmd_ready) begin
            m_cmd_valid   <= 1'b0;
            m_data_tdata  <= reg_addr;
            m_data_tlast  <= 1'b1;
            m_data_tvalid <= 1'b1;
            state         <= R_REG;
          end
        end
        R_REG: begin
          if (m_data_tready) begin
            m_data_tvalid        <= 1'b0;
            m_cmd_address        <= dev_addr;
            m_cmd_start          <= 1'b1;
            m_cmd_read           <= 1'b1;
            m_cmd_write          <= 1'b0;
            m_cmd_write_multiple <= 1'b0;
            m_cmd_stop           <= 1'b1;
            m_cmd_valid          <= 1'b1;
            state                <= R_CMD_R;
          end
        end
        R_CMD_R: begin
          if (m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
            s_rd_tready <= 1'b1;
            state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rd_tvalid) begin
            s_rd_tready <= 1'b0;
            rsp_rdata   <= s_rd_tdata;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef I2C_REG_TIMEOUT_EN
      if (timeout) begin
        m_cmd_valid   <= 1'b0;
        m_data_tvalid <= 1'b0;
        s_rd_tready   <= 1'b0;
        rsp_err       <= 1'b1;
        rsp_rdata     <= '0;
        rsp_valid     <= 1'b1;
        state         <= RESP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: table + random requests against a bus-level model.
// Build with I2C_REG_TIMEOUT_EN to also exercise the timeout abort.
module tb_i2c_reg_sequencer;

`ifdef I2C_REG_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [6:0] m_cmd_address;
  logic       m_cmd_start, m_cmd_read, m_cmd_write;
  logic       m_cmd_write_multiple, m_cmd_stop;
  logic       m_cmd_valid, m_cmd_ready;
  logic [7:0] m_data_tdata;
  logic       m_data_tvalid, m_data_tlast, m_data_tready;
  logic [7:0] s_rd_tdata;
  logic       s_rd_tvalid, s_rd_tready, s_rd_tlast;
  logic       i2c_busy, i2c_missed_ack;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start),
    .m_cmd_read(m_cmd_read), .m_cmd_write(m_cmd_write),
    .m_cmd_write_multiple(m_cmd_write_multiple),
    .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid),
    .m_data_tlast(m_data_tlast), .m_data_tready(m_data_tready),
    .s_rd_tdata(s_rd_tdata), .s_rd_tvalid(s_rd_tvalid),
    .s_rd_tready(s_rd_tready), .s_rd_tlast(s_rd_tlast),
    .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack)
  );

  logic [11:0] cmd_f;
  logic [8:0]  dat_f;
  logic [8:0]  rsp_f;
  logic [34:0] all_out;
  assign cmd_f = {m_cmd_address, m_cmd_start, m_cmd_read,
                  m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
  assign dat_f = {m_data_tdata, m_data_tlast};
  assign rsp_f = {rsp_rdata, rsp_err};
  assign all_out = {req_ready, rsp_valid, rsp_rdata, rsp_err, cmd_f,
                    m_cmd_valid, dat_f, m_data_tvalid, s_rd_tready};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mkcmd(input logic [6:0] a,
    input bit s, input bit r, input bit w, input bit wm, input bit p);
    return {a, s, r, w, wm, p};
  endfunction

  // environment: ideal i2c_master + single-device register slave
  int cyc = 0;
  int cmd_stall, data_stall, rsp_stall;
  int cmd_w, data_w, rsp_w;
  int busy_cd, rd_cd;
  bit rd_never, nack_req, nack_done, first_byte, wm_txn;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] slave_reg;
  logic [11:0] cmd_q[$];
  logic [8:0]  data_q[$];
  logic [8:0]  rsp_q[$];
  bit accepted;
  int accept_cyc;
  int hold_bad;
  bit pc, pd, pr;
  logic [11:0] pcf;
  logic [8:0]  pdf, prf;

  task automatic env_clear();
    busy_cd = 0; rd_cd = 0; rd_never = 0;
    i2c_busy = 0; i2c_missed_ack = 0;
    s_rd_tvalid = 0; s_rd_tlast = 0;
    pc = 0; pd = 0; pr = 0;
    cmd_w = 0; data_w = 0; rsp_w = 0;
    first_byte = 0; wm_txn = 0;
  endtask

  task automatic tick();
    bit ch, dh, rdh, rh;
    logic [11:0] c;
    logic [8:0] d;
    if (pc && !(m_cmd_valid && cmd_f == pcf)) hold_bad++;
    if (pd && !(m_data_tvalid && dat_f == pdf)) hold_bad++;
    if (pr && !(rsp_valid && rsp_f == prf)) hold_bad++;
    ch  = m_cmd_valid && m_cmd_ready;
    dh  = m_data_tvalid && m_data_tready;
    rdh = s_rd_tvalid && s_rd_tready;
    rh  = rsp_valid && rsp_ready;
    pc = m_cmd_valid && !m_cmd_ready;     pcf = cmd_f;
    pd = m_data_tvalid && !m_data_tready; pdf = dat_f;
    pr = rsp_valid && !rsp_ready;         prf = rsp_f;
    c = cmd_f;
    d = dat_f;
    if (req_valid && req_ready) begin
      accepted = 1;
      accept_cyc = cyc;
    end
    if (ch) begin cmd_q.push_back(c); cmd_w = 0; end
    if (dh) begin data_q.push_back(d); data_w = 0; end
    if (rh) begin rsp_q.push_back(rsp_f); rsp_w = 0; end
    @(posedge clk);
    #1;
    cyc++;
    i2c_missed_ack = 0;
    if (busy_cd > 0) begin
      busy_cd--;
      if (busy_cd == 0) i2c_busy = 0;
    end
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        s_rd_tvalid = 1; s_rd_tlast = 1;
        s_rd_tdata = mem[slave_reg];
      end
    end
    if (ch) begin
      i2c_busy = 1;
      wm_txn = c[1];
      if (c[3]) begin
        if (!rd_never) rd_cd = 3;
      end else begin
        first_byte = 1;
      end
    end
    if (dh) begin
      if (first_byte) begin
        slave_reg = d[8:1];
        first_byte = 0;
        if (nack_req && !nack_done) begin
          i2c_missed_ack = 1;
          nack_done = 1;
        end
      end else begin
        mem[slave_reg] = d[8:1];
      end
      if (d[0] && wm_txn) busy_cd = 3;
    end
    if (rdh) begin
      s_rd_tvalid = 0; s_rd_tlast = 0;
      busy_cd = 2;
    end
    if (m_cmd_valid && cmd_w < cmd_stall) begin
      m_cmd_ready = 0; cmd_w++;
    end else m_cmd_ready = 1;
    if (m_data_tvalid && data_w < data_stall) begin
      m_data_tready = 0; data_w++;
    end else m_data_tready = 1;
    if (rsp_valid && rsp_w < rsp_stall) begin
      rsp_ready = 0; rsp_w++;
    end else rsp_ready = 1;
  endtask

  task automatic send_req(input bit rw, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd);
    int n = 0;
    accepted = 0;
    req_valid = 1; req_rw = rw;
    req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    while (!accepted && n < 100) begin tick(); n++; end
    req_valid = 0;
    req_rw = 1'($urandom);
    req_dev_addr = 7'($urandom);
    req_reg_addr = 8'($urandom);
    req_wdata = 8'($urandom);
    check("accept", 64'(accepted), 64'd1);
  endtask

  task automatic do_req(input string nm, input bit rw,
    input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd,
    input bit nack, input int cs, input int ds, input int rs,
    input logic [7:0] er, input bit ee);
    logic [11:0] ec[$];
    logic [8:0]  ed[$];
    logic [8:0]  r;
    int n, rr_bad;
    cmd_q.delete(); data_q.delete(); rsp_q.delete();
    hold_bad = 0; rr_bad = 0;
    cmd_stall = cs; data_stall = ds; rsp_stall = rs;
    nack_req = nack; nack_done = 0;
    if (rw) begin
      ec.push_back(mkcmd(dev, 1, 0, 1, 0, 0));
      ec.push_back(mkcmd(dev, 1, 1, 0, 0, 1));
      ed.push_back({ra, 1'b1});
    end else begin
      ec.push_back(mkcmd(dev, 1, 0, 0, 1, 1));
      ed.push_back({ra, 1'b0});
      ed.push_back({wd, 1'b1});
    end
    send_req(rw, dev, ra, wd);
    check({nm, ".cmd_lat"}, 64'(m_cmd_valid), 64'd1);
    n = 0;
    while (rsp_q.size() == 0 && n < 3000) begin
      if (req_ready) rr_bad++;
      tick(); n++;
    end
    check({nm, ".rsp_cnt"}, 64'(rsp_q.size()), 64'd1);
    if (rsp_q.size() > 0) begin
      r = rsp_q[0];
      check({nm, ".rdata"}, 64'(r[8:1]), 64'(er));
      check({nm, ".err"}, 64'(r[0]), 64'(ee));
    end
    check({nm, ".cmd_cnt"}, 64'(cmd_q.size()), 64'(ec.size()));
    for (int i = 0; i < ec.size(); i++)
      if (i < cmd_q.size())
        check($sformatf("%s.cmd%0d", nm, i), 64'(cmd_q[i]), 64'(ec[i]));
    check({nm, ".dat_cnt"}, 64'(data_q.size()), 64'(ed.size()));
    for (int i = 0; i < ed.size(); i++)
      if (i < data_q.size())
        check($sformatf("%s.dat%0d", nm, i), 64'(data_q[i]), 64'(ed[i]));
    check({nm, ".hold"}, 64'(hold_bad), 64'd0);
    check({nm, ".req_ready_busy"}, 64'(rr_bad), 64'd0);
    check({nm, ".req_ready_back"}, 64'(req_ready), 64'd1);
    if (!rw) ref_mem[ra] = wd;
    n = 0;
    while (i2c_busy && n < 20) begin tick(); n++; end
  endtask

  typedef struct {
    bit         rw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    bit         nack;
    int         cs, ds, rs;
    logic [7:0] er;
    bit         ee;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n;
    bit rw, nk;
    logic [7:0] ra, wd, er;
    tbl[0] = '{0, 7'h50, 8'h12, 8'hA5, 0, 0, 0, 0, 8'h00, 0};
    tbl[1] = '{1, 7'h50, 8'h07, 8'h00, 0, 0, 0, 0, 8'h3C, 0};
    tbl[2] = '{0, 7'h50, 8'h20, 8'h5A, 1, 0, 0, 0, 8'h00, 1};
    tbl[3] = '{1, 7'h50, 8'h12, 8'h00, 0, 0, 0, 0, 8'hA5, 0};
    tbl[4] = '{0, 7'h50, 8'h30, 8'hC3, 0, 5, 5, 10, 8'h00, 0};
    tbl[5] = '{1, 7'h50, 8'h30, 8'h00, 0, 5, 5, 10, 8'hC3, 0};
    tbl[6] = '{1, 7'h50, 8'h20, 8'h00, 1, 0, 0, 0, 8'h5A, 1};
    tbl[7] = '{0, 7'h21, 8'hFF, 8'h00, 0, 1, 2, 3, 8'h00, 0};
    tbl[8] = '{1, 7'h7F, 8'hFF, 8'h11, 0, 0, 0, 0, 8'h00, 0};
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h3B;
      ref_mem[i] = 8'(i) ^ 8'h3B;
    end
    rst = 1;
    req_valid = 0; req_rw = 0;
    req_dev_addr = 0; req_reg_addr = 0; req_wdata = 0;
    rsp_ready = 0; m_cmd_ready = 0; m_data_tready = 0;
    s_rd_tdata = 0;
    cmd_stall = 0; data_stall = 0; rsp_stall = 0;
    env_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 64'(all_out), 64'd0);
    rst = 0;

    for (int i = 0; i < 9; i++)
      do_req($sformatf("vec%0d", i), tbl[i].rw, tbl[i].dev, tbl[i].ra,
             tbl[i].wd, tbl[i].nack, tbl[i].cs, tbl[i].ds, tbl[i].rs,
             tbl[i].er, tbl[i].ee);

    for (int i = 0; i < 30; i++) begin
      rw = 1'($urandom);
      ra = 8'($urandom_range(0, 15));
      wd = 8'($urandom);
      nk = ($urandom_range(0, 3) == 0);
      er = rw ? ref_mem[ra] : 8'h00;
      do_req($sformatf("rnd%0d", i), rw, 7'($urandom), ra, wd, nk,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), er, nk);
    end

    cmd_stall = 0; data_stall = 0; rsp_stall = 0;
    nack_req = 0;
    rd_never = 1;
    send_req(1, 7'h50, 8'h07, 8'h00);
    n = 0;
    while (!s_rd_tready && n < 50) begin tick(); n++; end
    check("reach_rdata", 64'(s_rd_tready), 64'd1);
    rst = 1;
    #1;
    check("midop_reset_outs", 64'(all_out), 64'd0);
    env_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    while (!req_ready && n < 5) begin tick(); n++; end
    check("req_ready_after_rst", 64'(req_ready), 64'd1);
    do_req("post_rst_wr", 0, 7'h50, 8'h44, 8'h9E, 0, 0, 0, 0, 8'h00, 0);
    do_req("post_rst_rd", 1, 7'h50, 8'h44, 8'h00, 0, 0, 0, 0, 8'h9E, 0);

`ifdef I2C_REG_TIMEOUT_EN
    rd_never = 1;
    rsp_q.delete();
    send_req(1, 7'h50, 8'h07, 8'h00);
    n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    check("to_latency", 64'(cyc - (accept_cyc + 1)), 64'd50);
    check("to_rdata", 64'(rsp_rdata), 64'd0);
    check("to_err", 64'(rsp_err), 64'd1);
    n = 0;
    while (rsp_q.size() == 0 && n < 20) begin tick(); n++; end
    check("to_rsp_cnt", 64'(rsp_q.size()), 64'd1);
    env_clear();
    do_req("post_to_wr", 0, 7'h50, 8'h55, 8'h66, 0, 0, 0, 0, 8'h00, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
